// File: rtl/net_tx_pkg.sv
// rtl/net_tx_pkg.sv - shared types and helpers for the transmit frame buffer
package net_tx_pkg;

  localparam int NET_MIN_FRAME_BYTES = 60;

  // One queued frame: beats stored in RAM and the byte enables of its final beat
  typedef struct packed {
    logic [7:0] word_count;
    logic [7:0] last_keep;
  } net_tx_desc_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_PRIME,
    RD_SEND
  } net_tx_rd_state_e;

  // Number of valid bytes in a beat's keep mask
  function automatic logic [3:0] keep_to_bytes(input logic [7:0] keep);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, keep[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/net_tx_desc_fifo.sv
// rtl/net_tx_desc_fifo.sv - synchronous FIFO of frame descriptors
module net_tx_desc_fifo
  import net_tx_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  net_tx_desc_t           data_i,
  input  logic                   pop_i,
  output net_tx_desc_t           data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  net_tx_desc_t mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic         do_push;
  logic         do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = count_o[AW];
  assign empty_o = (count_o == '0);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; the extra wrap bit separates full from empty
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Descriptor storage
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/net_tx_frame_buffer.sv
// rtl/net_tx_frame_buffer.sv - store-and-forward TX frame buffer (runt padding under NET_TX_PAD_EN)
module net_tx_frame_buffer
  import net_tx_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int DEPTH_WORDS     = 512,
  parameter int MAX_FRAME_WORDS = 190,
  parameter int DESC_DEPTH      = 16
) (
  input  logic                          clk156,
  input  logic                          aresetn,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]       s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]       m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [15:0]                   drop_count,
  output logic [$clog2(DESC_DEPTH):0]   frames_queued
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Reset asserts immediately, releases two clocks later
  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // Write side state
  logic [AW:0]  wptr_q, wptr_d, wcommit_q, wcommit_d, rptr_c_q, rptr_c_d, used;
  logic [7:0]   wcount_q, wcount_d;
  logic         discard_q, discard_d;
  logic [15:0]  drop_q, drop_d;
  logic         wr_en, push, s_fire;
  net_tx_desc_t push_desc, desc_head;
  logic         desc_full, desc_empty;

  // Read side state
  net_tx_rd_state_e state_q, state_d;
  net_tx_desc_t     desc_q, desc_d;
  logic [AW-1:0]    nxt_q, nxt_d, raddr;
  logic [7:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d, ram_q, fmt_data;
  logic [KW-1:0]    tkeep_q, tkeep_d, fmt_keep, byte_en, lk;
  logic             tlast_q, tlast_d, tvalid_q, tvalid_d, stored_q, stored_d;
  logic             fmt_last, fmt_stored, fmt_lastst, pad_active;
  logic             pop, load, m_hs;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

  // Uncommitted write pointer minus committed read pointer; top bit set means no free word
  assign used          = wptr_q - rptr_c_q;
  assign s_axis_tready = rst_n & (discard_q | (~used[AW] & ~(desc_full & s_axis_tlast)));
  assign s_fire        = s_axis_tvalid & s_axis_tready;
  assign push_desc     = '{word_count: wcount_q + 8'd1, last_keep: 8'(s_axis_tkeep)};

  // Write side: store beats, commit on tlast, rewind and count oversize frames
  always_comb begin
    wptr_d    = wptr_q;
    wcommit_d = wcommit_q;
    wcount_d  = wcount_q;
    discard_d = discard_q;
    drop_d    = drop_q;
    wr_en     = 1'b0;
    push      = 1'b0;
    if (s_fire) begin
      if (discard_q) begin
        if (s_axis_tlast) begin
          discard_d = 1'b0;
          if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        end
      end else if (s_axis_tlast) begin
        wr_en     = 1'b1;
        push      = 1'b1;
        wptr_d    = wptr_q + PTR_ONE;
        wcommit_d = wptr_q + PTR_ONE;
        wcount_d  = '0;
      end else if (wcount_q == 8'(MAX_FRAME_WORDS - 1)) begin
        discard_d = 1'b1;
        wptr_d    = wcommit_q;
        wcount_d  = '0;
      end else begin
        wr_en    = 1'b1;
        wptr_d   = wptr_q + PTR_ONE;
        wcount_d = wcount_q + 8'd1;
      end
    end
  end

  net_tx_desc_fifo #(.DEPTH(DESC_DEPTH)) u_desc_fifo (
    .clk_i   (clk156),
    .rst_ni  (rst_n),
    .push_i  (push),
    .data_i  (push_desc),
    .pop_i   (pop),
    .data_o  (desc_head),
    .full_o  (desc_full),
    .empty_o (desc_empty),
    .count_o (frames_queued)
  );

  // Data RAM with one-cycle registered read
  always_ff @(posedge clk156) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= s_axis_tdata;
    ram_q <= mem_q[raddr];
  end

`ifdef NET_TX_PAD_EN
  assign pad_active = ({desc_q.word_count - 8'd1, 3'b000} + 11'(keep_to_bytes(desc_q.last_keep)))
                      < 11'(NET_MIN_FRAME_BYTES);
`else
  assign pad_active = 1'b0;
`endif

  assign lk = KW'(desc_q.last_keep);

  // Shape the beat at index idx_q: mask trailing bytes, zero pad beats, pick keep/last
  always_comb begin
    fmt_data   = '0;
    fmt_stored = (idx_q < desc_q.word_count);
    fmt_lastst = (idx_q == desc_q.word_count - 8'd1);
    byte_en    = fmt_lastst ? lk : (fmt_stored ? '1 : '0);
    for (int b = 0; b < KW; b++) begin
      fmt_data[b*8 +: 8] = byte_en[b] ? ram_q[b*8 +: 8] : 8'h00;
    end
    if (pad_active) begin
      fmt_keep = (idx_q == 8'd7) ? KW'(8'h0F) : '1;
      fmt_last = (idx_q == 8'd7);
    end else begin
      fmt_keep = fmt_lastst ? lk : '1;
      fmt_last = fmt_lastst;
    end
  end

  assign m_hs     = tvalid_q & m_axis_tready;
  assign rptr_c_d = rptr_c_q + {{AW{1'b0}}, m_hs & stored_q};

  // Read FSM: pop a descriptor, prime the output register, then stream with RAM prefetch
  always_comb begin
    state_d  = state_q;
    desc_d   = desc_q;
    nxt_d    = nxt_q;
    idx_d    = idx_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    stored_d = stored_q;
    pop      = 1'b0;
    load     = 1'b0;
    raddr    = nxt_q;
    unique case (state_q)
      RD_IDLE: begin
        raddr = rptr_c_q[AW-1:0];
        if (!desc_empty) begin
          pop     = 1'b1;
          desc_d  = desc_head;
          nxt_d   = rptr_c_q[AW-1:0];
          idx_d   = '0;
          state_d = RD_PRIME;
        end
      end
      RD_PRIME: begin
        load    = 1'b1;
        state_d = RD_SEND;
      end
      RD_SEND: begin
        if (m_hs) begin
          if (tlast_q) begin
            tvalid_d = 1'b0;
            raddr    = rptr_c_d[AW-1:0];
            if (!desc_empty) begin
              pop     = 1'b1;
              desc_d  = desc_head;
              nxt_d   = rptr_c_d[AW-1:0];
              idx_d   = '0;
              state_d = RD_PRIME;
            end else begin
              state_d = RD_IDLE;
            end
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
    if (load) begin
      tdata_d  = fmt_data;
      tkeep_d  = fmt_keep;
      tlast_d  = fmt_last;
      stored_d = fmt_stored;
      tvalid_d = 1'b1;
      raddr    = nxt_q + ADDR_ONE;
      nxt_d    = nxt_q + ADDR_ONE;
      idx_d    = idx_q + 8'd1;
    end
  end

  // State registers for both sides
  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      wcommit_q <= '0;
      rptr_c_q  <= '0;
      wcount_q  <= '0;
      discard_q <= 1'b0;
      drop_q    <= '0;
      state_q   <= RD_IDLE;
      desc_q    <= '0;
      nxt_q     <= '0;
      idx_q     <= '0;
      tdata_q   <= '0;
      tkeep_q   <= '0;
      tlast_q   <= 1'b0;
      tvalid_q  <= 1'b0;
      stored_q  <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      wcommit_q <= wcommit_d;
      rptr_c_q  <= rptr_c_d;
      wcount_q  <= wcount_d;
      discard_q <= discard_d;
      drop_q    <= drop_d;
      state_q   <= state_d;
      desc_q    <= desc_d;
      nxt_q     <= nxt_d;
      idx_q     <= idx_d;
      tdata_q   <= tdata_d;
      tkeep_q   <= tkeep_d;
      tlast_q   <= tlast_d;
      tvalid_q  <= tvalid_d;
      stored_q  <= stored_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_net_tx_frame_buffer.sv
// tb/tb_net_tx_frame_buffer.sv - self-checking bench for net_tx_frame_buffer
module tb_net_tx_frame_buffer;

  localparam int MAXW = 190;
`ifdef NET_TX_PAD_EN
  localparam bit        PAD_ON    = 1'b1;
  localparam int        PAD_BEATS = 8;
  localparam logic [7:0] PAD_KEEP = 8'h0F;
`else
  localparam bit        PAD_ON    = 1'b0;
  localparam int        PAD_BEATS = 1;
  localparam logic [7:0] PAD_KEEP = 8'hFF;
`endif

  logic        clk156 = 1'b0;
  logic        aresetn;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tvalid, s_tlast, s_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid, m_tlast, m_tready;
  logic [15:0] drop_count;
  logic [4:0]  frames_queued;

  always #5 clk156 = ~clk156;

  net_tx_frame_buffer dut (
    .clk156        (clk156),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .drop_count    (drop_count),
    .frames_queued (frames_queued)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] cur_d[$];
  beat_t       e;
  int total = 0, bad = 0, cyc = 0, exp_drops = 0, got_beats = 0;
  int last_tlast_cyc = -1, first_valid_cyc = -1;
  logic [7:0]  last_keep_seen = 8'h00;
  logic        mon_en = 1'b0;
  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0, mid = 1'b0;
  logic [63:0] pd = '0;
  logic [7:0]  pk = '0;

  always @(posedge clk156) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int f, input int i);
    logic [31:0] a, b;
    a = f;
    b = i;
    return {a[7:0], b[7:0], ~b[15:0], a[15:0] ^ 16'h5a5a, b[15:0]};
  endfunction

  // Frame as a byte string: trim to its length, pad runts, re-chunk into 8-byte beats
  task automatic model_frame(input logic [7:0] lastk);
    byte unsigned bytes[$];
    int n, nb;
    beat_t bt;
    n = cur_d.size();
    if (n > MAXW) begin
      exp_drops++;
      return;
    end
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++)
        if (i < n - 1 || lastk[b]) bytes.push_back(cur_d[i][b*8 +: 8]);
    if (PAD_ON) while (bytes.size() < 60) bytes.push_back(8'h00);
    nb = (bytes.size() + 7) / 8;
    for (int j = 0; j < nb; j++) begin
      bt = '0;
      for (int b = 0; b < 8; b++)
        if (j * 8 + b < bytes.size()) begin
          bt.d[b*8 +: 8] = bytes[j*8+b];
          bt.k[b] = 1'b1;
        end
      bt.l = (j == nb - 1);
      exp_q.push_back(bt);
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int t;
    t = 0;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
    @(negedge clk156);
    while (!s_tready) begin
      t++;
      if (t > 4000) begin
        total++; bad++;
        $display("FAIL in_accept_timeout actual=0 required=1");
        break;
      end
      @(negedge clk156);
    end
    if (s_tready) begin
      cur_d.push_back(d);
      if (l) begin
        last_tlast_cyc = cyc;
        model_frame(k);
        cur_d.delete();
      end
    end
    @(posedge clk156); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic send_frame(input int f, input int n, input logic [7:0] lk, input bit bubbles);
    for (int i = 0; i < n; i++) begin
      if (bubbles && (i % 2 == 1)) begin @(posedge clk156); #1; end
      send_beat(mk(f, i), (i == n - 1) ? lk : 8'hFF, i == n - 1);
    end
  endtask

  task automatic set_mready(input logic v);
    @(posedge clk156); #1;
    m_tready = v;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || m_tvalid) && t < 5000) begin
      @(negedge clk156);
      t++;
    end
    chk(name, exp_q.size(), 0);
    @(posedge clk156); #1;
  endtask

  // Output monitor: scoreboard compare on every handshake plus hold and no-gap rules
  always @(negedge clk156) begin
    if (mon_en) begin
      if (pv && !pr) begin
        chk("hold_valid", m_tvalid, 1);
        chk("hold_data", m_tdata, pd);
        chk("hold_keep", m_tkeep, pk);
        chk("hold_last", m_tlast, pl);
      end
      if (mid) chk("no_gap", m_tvalid, 1);
      if (m_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat actual=%0h required=none", m_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", m_tdata, e.d);
          chk("out_keep", m_tkeep, e.k);
          chk("out_last", m_tlast, e.l);
        end
        got_beats++;
        last_keep_seen = m_tkeep;
        mid = !m_tlast;
      end
      pv = m_tvalid; pr = m_tready; pd = m_tdata; pk = m_tkeep; pl = m_tlast;
    end else begin
      pv = 1'b0;
      mid = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int g0;
    aresetn = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0; m_tready = 1'b1;
    repeat (3) @(negedge clk156);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tkeep", m_tkeep, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_queued", frames_queued, 0);
    @(posedge clk156); #1;
    aresetn = 1'b1;
    @(posedge clk156); @(negedge clk156);
    chk("sync_tready_lo", s_tready, 0);
    @(posedge clk156); @(negedge clk156);
    chk("sync_tready_hi", s_tready, 1);
    mon_en = 1'b1;
    @(posedge clk156); #1;

    // 3-beat frame with input bubbles, last keep 0x3F
    first_valid_cyc = -1;
    g0 = got_beats;
    send_frame(1, 3, 8'h3F, 1'b1);
    drain("drain_t1");
    chk("latency", first_valid_cyc - last_tlast_cyc, 3);
    chk("t1_beats", got_beats - g0, 3);
    chk("t1_last_keep", last_keep_seen, 8'h3F);

    // 9-beat frame, short last beat (not a runt)
    send_frame(2, 9, 8'h07, 1'b0);
    drain("drain_t1b");

    // Oversize: 200 beats, tlast only on the last
    g0 = got_beats;
    send_frame(3, 200, 8'hFF, 1'b0);
    repeat (10) @(posedge clk156); #1;
    chk("drop_lit", drop_count, 1);
    chk("drop_model", drop_count, exp_drops);
    chk("drop_no_out", got_beats - g0, 0);
    send_frame(4, 2, 8'h01, 1'b1);
    drain("drain_t2");
    chk("t2_beats", got_beats - g0, 2);

    // Single-beat runt
    g0 = got_beats;
    send_frame(5, 1, 8'hFF, 1'b0);
    drain("drain_t3");
    chk("pad_beats", got_beats - g0, PAD_BEATS);
    chk("pad_last_keep", last_keep_seen, PAD_KEEP);

    // Descriptor FIFO full: one frame sits in the output stage, 16 more queue
    set_mready(1'b0);
    for (int i = 0; i < 17; i++) send_beat(mk(40, i), 8'h0F, 1'b1);
    s_tdata = mk(40, 17); s_tkeep = 8'h0F; s_tlast = 1'b1; s_tvalid = 1'b1;
    @(negedge clk156);
    chk("descfull_tready", s_tready, 0);
    chk("descfull_queued", frames_queued, 16);
    set_mready(1'b1);
    send_beat(mk(40, 17), 8'h0F, 1'b1);
    drain("drain_t4");

    // RAM full: 190+190+132 = 512 words with output stalled
    set_mready(1'b0);
    send_frame(50, 190, 8'hFF, 1'b0);
    send_frame(51, 190, 8'hFF, 1'b0);
    send_frame(52, 132, 8'h7F, 1'b0);
    s_tdata = mk(53, 0); s_tkeep = 8'hFF; s_tlast = 1'b0; s_tvalid = 1'b1;
    @(negedge clk156);
    chk("ramfull_tready", s_tready, 0);
    chk("ramfull_queued", frames_queued, 2);
    set_mready(1'b1);
    send_frame(53, 3, 8'h03, 1'b0);
    drain("drain_t5");

    // Reset while a frame is streaming out
    g0 = got_beats;
    send_frame(60, 20, 8'hFF, 1'b0);
    for (int t = 0; t < 200 && got_beats - g0 < 5; t++) @(negedge clk156);
    chk("t6_started", (got_beats - g0 >= 5) ? 1 : 0, 1);
    #2;
    mon_en = 1'b0;
    aresetn = 1'b0;
    #1;
    chk("arst_m_tvalid", m_tvalid, 0);
    chk("arst_m_tdata", m_tdata, 0);
    chk("arst_m_tkeep", m_tkeep, 0);
    chk("arst_m_tlast", m_tlast, 0);
    chk("arst_s_tready", s_tready, 0);
    chk("arst_drop", drop_count, 0);
    chk("arst_queued", frames_queued, 0);
    exp_q.delete();
    cur_d.delete();
    exp_drops = 0;
    repeat (2) @(posedge clk156); #1;
    aresetn = 1'b1;
    repeat (3) @(posedge clk156); #1;
    mon_en = 1'b1;
    g0 = got_beats;
    send_frame(61, 9, 8'h1F, 1'b1);
    drain("drain_t6");
    chk("t6_beats", got_beats - g0, 9);
    chk("end_queued", frames_queued, 0);
    chk("end_drop", drop_count, exp_drops);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
